// File: rtl/me_fetch_scheduler_pkg.sv
// Shared types and widths for the motion-estimation fetch scheduler.
package me_fetch_scheduler_pkg;

  localparam int CUR_W = 32;
  localparam int REF_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter width that stays legal for a count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/me_valid_delay.sv
// Delays the SRAM read strobe by the read latency so the data-valid lines up
// with the returning words; a flush drops every read still in flight.
module me_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic valid_in,
  output logic valid_out,
  output logic pending
);

  localparam logic [DEPTH-1:0] OUT_BIT = DEPTH'(1) << (DEPTH - 1);

  logic [DEPTH-1:0] pipe;

  // NOTE: every register in this design is a plain flop (no RAM arrays), so
  // all of them are cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if (flush) begin
      pipe <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value regardless of statement order.
      pipe <= DEPTH'({pipe, valid_in});
    end
  end

  assign valid_out = pipe[DEPTH-1];
  // Reads that will still emerge after the current output cycle.
  assign pending   = |(pipe & ~OUT_BIT);

endmodule

// File: rtl/me_fetch_scheduler.sv
// Issues one macroblock of paired current/reference SRAM reads and forwards the
// returning words to the ME input buffer with a latency-aligned valid strobe.
module me_fetch_scheduler
  import me_fetch_scheduler_pkg::*;
#(
  parameter int BEATS     = 64,
  parameter int CUR_WORDS = 64,
  parameter int READ_LAT  = 1,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] cur_base_i,
  input  logic [ADDR_W-1:0] ref_base_i,
  input  logic [CUR_W-1:0]  cur_rdata_i,
  input  logic [REF_W-1:0]  ref_rdata_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic [ADDR_W-1:0] ref_addr_o,
  output logic              en_o,
  output logic [CUR_W-1:0]  cur_in_o,
  output logic [REF_W-1:0]  ref_in_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BEAT_W    = cnt_w(BEATS);
  localparam int CUR_OFF_W = cnt_w(CUR_WORDS);

  state_t               state, next_state;
  logic                 fire;
  logic                 flush;
  logic                 last_beat;
  logic                 pending;
  logic [BEAT_W-1:0]    beat;
  logic [CUR_OFF_W-1:0] cur_off;
  logic [ADDR_W-1:0]    cur_base, ref_base;
  logic [ADDR_W-1:0]    cur_src, ref_src;

  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: defaults first, so no path through the case leaves an output
  // unassigned and infers a latch.
  always_comb begin
    next_state = state;
    fire       = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        // abort_i is not looked at here: a simultaneous start wins.
        if (start_i) begin
          next_state = ISSUE;
          fire       = !stall_i;
        end
      end
      ISSUE: begin
        if (abort_i) begin
          next_state = IDLE;
          flush      = 1'b1;
        end else if (!stall_i) begin
          fire = 1'b1;
          if (last_beat) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_i) begin
          next_state = IDLE;
          flush      = 1'b1;
        end else if (!rd_en_o && !pending) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
        flush      = abort_i;
      end
      default: next_state = IDLE;
    endcase
  end

  // The first beat is fired in the start cycle, before the bases are latched.
  assign cur_src = (state == IDLE) ? cur_base_i : cur_base;
  assign ref_src = (state == IDLE) ? ref_base_i : ref_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_o    <= 1'b0;
      cur_addr_o <= '0;
      ref_addr_o <= '0;
      cur_base   <= '0;
      ref_base   <= '0;
      beat       <= '0;
      cur_off    <= '0;
    end else begin
      rd_en_o <= fire;
      if (state == IDLE && start_i) begin
        cur_base <= cur_base_i;
        ref_base <= ref_base_i;
      end
      if (fire) begin
        cur_addr_o <= cur_src + ADDR_W'(cur_off);
        ref_addr_o <= ref_src + ADDR_W'(beat);
        beat       <= last_beat ? '0 : beat + 1'b1;
        cur_off    <= (cur_off == CUR_OFF_W'(CUR_WORDS - 1)) ? '0 : cur_off + 1'b1;
      end else if (next_state == IDLE) begin
        beat    <= '0;
        cur_off <= '0;
      end
    end
  end

  me_valid_delay #(
    .DEPTH (READ_LAT)
  ) u_valid_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .valid_in  (rd_en_o),
    .valid_out (en_o),
    .pending   (pending)
  );

  assign cur_in_o = en_o ? cur_rdata_i : '0;
  assign ref_in_o = en_o ? ref_rdata_i : '0;
  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);

endmodule

// File: tb/tb_me_fetch_scheduler.sv
// Self-checking bench for me_fetch_scheduler: scenario table plus scoreboard of
// expected read data, and a hand-written reset-in-flight sequence.
module tb_me_fetch_scheduler;

  localparam int BEATS     = 8;
  localparam int CUR_WORDS = 4;
  localparam int READ_LAT  = 1;
  localparam int ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              stall_i = 1'b0;
  logic [ADDR_W-1:0] cur_base_i = '0;
  logic [ADDR_W-1:0] ref_base_i = '0;
  logic [31:0]       cur_rdata_i = '0;
  logic [63:0]       ref_rdata_i = '0;
  logic              rd_en_o;
  logic [ADDR_W-1:0] cur_addr_o;
  logic [ADDR_W-1:0] ref_addr_o;
  logic              en_o;
  logic [31:0]       cur_in_o;
  logic [63:0]       ref_in_o;
  logic              busy_o;
  logic              done_o;

  me_fetch_scheduler #(
    .BEATS     (BEATS),
    .CUR_WORDS (CUR_WORDS),
    .READ_LAT  (READ_LAT),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .stall_i     (stall_i),
    .cur_base_i  (cur_base_i),
    .ref_base_i  (ref_base_i),
    .cur_rdata_i (cur_rdata_i),
    .ref_rdata_i (ref_rdata_i),
    .rd_en_o     (rd_en_o),
    .cur_addr_o  (cur_addr_o),
    .ref_addr_o  (ref_addr_o),
    .en_o        (en_o),
    .cur_in_o    (cur_in_o),
    .ref_in_o    (ref_in_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cur_pat(input logic [ADDR_W-1:0] a);
    return {a, 6'h2A, ~a, 6'h15};
  endfunction

  function automatic logic [63:0] ref_pat(input logic [ADDR_W-1:0] a);
    return {cur_pat(a) ^ 32'h5A5A_0F0F, ~a, 22'h3C3C3C};
  endfunction

  // One-cycle-latency SRAM pair: data depends only on the address read.
  always @(posedge clk) begin
    if (rd_en_o) begin
      cur_rdata_i <= cur_pat(cur_addr_o);
      ref_rdata_i <= ref_pat(ref_addr_o);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] cur_d;
    logic [63:0] ref_d;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] cur_base;
    logic [ADDR_W-1:0] ref_base;
    int                stall_from;
    int                stall_len;
    int                abort_at;
    int                start2_at;
    int                exp_reads;
    int                exp_dones;
    int                exp_done_cyc;
    int                exp_idle_cyc;
  } vec_t;

  vec_t vecs[10];

  // Start in cycle 0, then cycles 1.. drive stall/abort/second start and sample
  // at the falling edge; addresses come from the bench's own beat model.
  task automatic run_vec(input vec_t v);
    int   beat = 0;
    int   reads = 0;
    int   dones = 0;
    int   done_cyc = -1;
    logic [ADDR_W-1:0] ecur, eref;
    exp_t e;
    @(posedge clk); #1;
    start_i    = 1'b1;
    cur_base_i = v.cur_base;
    ref_base_i = v.ref_base;
    stall_i    = 1'b0;
    abort_i    = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= v.exp_idle_cyc + 2; c++) begin
      @(posedge clk); #1;
      start_i = (c == v.start2_at);
      if (start_i) begin
        cur_base_i = 10'h055;
        ref_base_i = 10'h2AA;
      end
      stall_i = (c >= v.stall_from) && (c < v.stall_from + v.stall_len);
      abort_i = (c == v.abort_at);
      @(negedge clk);
      if (c == 1) begin
        check({v.name, " rd_en at cycle 1"}, 64'(rd_en_o), 64'd1);
        check({v.name, " busy at cycle 1"}, 64'(busy_o), 64'd1);
      end
      if (c == v.exp_idle_cyc - 1) check({v.name, " busy before idle"}, 64'(busy_o), 64'd1);
      if (c == v.exp_idle_cyc)     check({v.name, " busy cleared"}, 64'(busy_o), 64'd0);
      if (rd_en_o) begin
        ecur = v.cur_base + ADDR_W'(beat % CUR_WORDS);
        eref = v.ref_base + ADDR_W'(beat);
        check({v.name, " cur_addr"}, 64'(cur_addr_o), 64'(ecur));
        check({v.name, " ref_addr"}, 64'(ref_addr_o), 64'(eref));
        sb.push_back('{cur_d: cur_pat(ecur), ref_d: ref_pat(eref)});
        beat++;
        reads++;
      end
      if (en_o) begin
        if (sb.size() == 0) begin
          check({v.name, " unexpected en_o"}, 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check({v.name, " cur_in"}, 64'(cur_in_o), 64'(e.cur_d));
          check({v.name, " ref_in"}, ref_in_o, e.ref_d);
        end
      end else begin
        check({v.name, " data zero without en"}, 64'((|cur_in_o) || (|ref_in_o)), 64'd0);
      end
      if (done_o) begin
        dones++;
        done_cyc = c;
      end
      if (c == v.abort_at) sb.delete();
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    abort_i = 1'b0;
    check({v.name, " read count"}, 64'(reads), 64'(v.exp_reads));
    check({v.name, " done count"}, 64'(dones), 64'(v.exp_dones));
    if (v.exp_dones == 1) check({v.name, " done cycle"}, 64'(done_cyc), 64'(v.exp_done_cyc));
    check({v.name, " outstanding data"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    //           name          cur     ref     stF sL abrt st2 rd dn dcyc idle
    vecs[0] = '{"basic",       10'h010, 10'h100, 0, 0, -1, -1, 8, 1, 10, 11};
    vecs[1] = '{"stall_3_4",   10'h010, 10'h100, 3, 2, -1, -1, 8, 1, 12, 13};
    vecs[2] = '{"stall_last",  10'h010, 10'h100, 7, 3, -1, -1, 8, 1, 13, 14};
    vecs[3] = '{"wrap",        10'h3FE, 10'h3FE, 0, 0, -1, -1, 8, 1, 10, 11};
    vecs[4] = '{"abort_4",     10'h010, 10'h100, 0, 0,  4, -1, 4, 0, -1,  5};
    vecs[5] = '{"after_abort", 10'h021, 10'h0F0, 0, 0, -1, -1, 8, 1, 10, 11};
    vecs[6] = '{"start_busy",  10'h010, 10'h100, 0, 0, -1,  3, 8, 1, 10, 11};
    vecs[7] = '{"start_done",  10'h123, 10'h200, 0, 0, -1, 10, 8, 1, 10, 11};
    vecs[8] = '{"abort_last",  10'h010, 10'h100, 0, 0,  7, -1, 7, 0, -1,  8};
    vecs[9] = '{"abort_drain", 10'h010, 10'h100, 0, 0,  9, -1, 8, 0, -1, 10};

    #2;
    check("reset rd_en", 64'(rd_en_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    check("reset en", 64'(en_o), 64'd0);
    check("reset addrs", 64'({cur_addr_o, ref_addr_o}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset asserted mid-macroblock clears the outputs without waiting for a clock.
    @(posedge clk); #1;
    start_i    = 1'b1;
    cur_base_i = 10'h040;
    ref_base_i = 10'h180;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (c == 4) check("busy before reset", 64'(busy_o), 64'd1);
      if (c == 5) begin
        rst_n = 1'b0;
        #1;
        check("async reset rd_en", 64'(rd_en_o), 64'd0);
        check("async reset busy", 64'(busy_o), 64'd0);
        check("async reset en", 64'(en_o), 64'd0);
        check("async reset done", 64'(done_o), 64'd0);
        check("async reset cur_addr", 64'(cur_addr_o), 64'd0);
        check("async reset ref_addr", 64'(ref_addr_o), 64'd0);
        check("async reset data", 64'((|cur_in_o) || (|ref_in_o)), 64'd0);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post-reset idle busy", 64'(busy_o), 64'd0);
      check("post-reset no done", 64'(done_o), 64'd0);
      check("post-reset no en", 64'(en_o), 64'd0);
    end
    sb.delete();
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
